// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: latches a packed BCD word and time-multiplexes its digits onto one shared
// seven-segment bus with a one-hot digit enable, per-digit decimal point, blanking and
// selectable output polarity. All outputs are registered.
//
// Optional build macro: LEADING_ZERO_SUPPRESS_EN
//   defined   - digits above digit 0 that are zero, with only zeros above them, show no segments
//               (their digit enable and decimal point still operate)
//   undefined - every digit is decoded, zeros show as "0"

module seg7_scan_driver #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  bad
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);

    // XOR masks that turn active-high values into the board's polarity
    localparam logic [6:0]        SEG_POL = {7{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_POL  = {DIGITS{ACTIVE_LOW}};
    localparam logic              DP_POL  = ACTIVE_LOW;

    logic [4*DIGITS-1:0] data_q;
    logic [DIGITS-1:0]   dp_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q;

    logic [6:0]          seg_q;
    logic                dp_out_q;
    logic [DIGITS-1:0]   an_q;
    logic                bad_q;

    logic [3:0]          cur_digit;
    logic                cur_dp;
    logic                cur_supp;
    logic [DIGITS-1:0]   an_hi;
    logic [DIGITS-1:0]   supp_vec;
    logic [6:0]          seg_hi;

    // Active-high {a..g} pattern for one BCD digit; codes 10-15 are dark
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Data latch, prescaler and digit index; load never disturbs the scan timing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            dp_q   <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
        end else begin
            if (load) begin
                data_q <= bcd;
                dp_q   <= dp_in;
            end
            if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
                idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_SUPPRESS_EN
    // A digit above 0 is suppressed while it and everything above it are zero
    always_comb begin : lz_calc
        logic zero_run;
        zero_run = 1'b1;
        supp_vec = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_run    = zero_run & (data_q[4*i +: 4] == 4'd0);
            supp_vec[i] = zero_run;
        end
    end
`else
    // Every digit is always decoded
    always_comb begin
        supp_vec = '0;
    end
`endif

    // Select the digit under scan and form the active-high output values
    always_comb begin
        cur_digit = 4'd0;
        cur_dp    = 1'b0;
        cur_supp  = 1'b0;
        an_hi     = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = data_q[4*i +: 4];
                cur_dp    = dp_q[i];
                cur_supp  = supp_vec[i];
                an_hi[i]  = 1'b1;
            end
        end
        seg_hi = cur_supp ? 7'b0000000 : decode(cur_digit);
    end

    // Registered output stage; blank darkens the display but bad keeps tracking the digit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q    <= SEG_POL;
            dp_out_q <= DP_POL;
            an_q     <= AN_POL;
            bad_q    <= 1'b0;
        end else begin
            bad_q <= (cur_digit > 4'd9);
            if (blank) begin
                seg_q    <= SEG_POL;
                dp_out_q <= DP_POL;
                an_q     <= AN_POL;
            end else begin
                seg_q    <= seg_hi ^ SEG_POL;
                dp_out_q <= cur_dp ^ DP_POL;
                an_q     <= an_hi ^ AN_POL;
            end
        end
    end

    assign seg = seg_q;
    assign dp  = dp_out_q;
    assign an  = an_q;
    assign bad = bad_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (active-high and active-low) share all inputs.
// Table of per-digit vectors plus hand sequences for async reset, frame timing and blanking.

module tb_seg7_scan_driver;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        load   = 1'b0;
    logic        blank  = 1'b0;
    logic [15:0] bcd    = 16'h0000;
    logic [3:0]  dp_in  = 4'b0000;

    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  an0, an1;
    logic        bad0, bad1;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .reset(reset), .bcd(bcd), .dp_in(dp_in), .load(load), .blank(blank),
        .seg(seg0), .dp(dp0), .an(an0), .bad(bad0)
    );

    seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .reset(reset), .bcd(bcd), .dp_in(dp_in), .load(load), .blank(blank),
        .seg(seg1), .dp(dp1), .an(an1), .bad(bad1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dpi;
        int          digit;
        logic [6:0]  seg;
        logic        dp;
        logic        bad;
        logic        supp;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(logic [15:0] b, logic [3:0] d, int g, logic [6:0] s,
                                logic p, logic bd, logic sp);
        vec_t v;
        v.bcd = b; v.dpi = d; v.digit = g; v.seg = s; v.dp = p; v.bad = bd; v.supp = sp;
        return v;
    endfunction

    // Digit shown after edge k (k>=1) since reset release: 4 cycles per digit, 4 digits
    function automatic int shown(int k);
        return ((k - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] oh(int d);
        logic [3:0] one;
        one = 4'b0001;
        return one << d;
    endfunction

    function automatic logic [6:0] exp_seg(vec_t v);
`ifdef LEADING_ZERO_SUPPRESS_EN
        return v.supp ? 7'b0000000 : v.seg;
`else
        return v.seg;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0b required %0b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    initial begin
        vec_t       v;
        int         l;
        bit         found;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;

        vecs[0]  = mk(16'h1234, 4'b0100, 0, 7'b0110011, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(16'h1234, 4'b0100, 1, 7'b1111001, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(16'h1234, 4'b0100, 2, 7'b1101101, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(16'h1234, 4'b0100, 3, 7'b0110000, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(16'h00A5, 4'b0000, 0, 7'b1011011, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(16'h00A5, 4'b0000, 1, 7'b0000000, 1'b0, 1'b1, 1'b0);
        vecs[6]  = mk(16'h00A5, 4'b0000, 2, 7'b1111110, 1'b0, 1'b0, 1'b1);
        vecs[7]  = mk(16'h00A5, 4'b0000, 3, 7'b1111110, 1'b0, 1'b0, 1'b1);
        vecs[8]  = mk(16'h0008, 4'b0011, 0, 7'b1111111, 1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(16'h0008, 4'b0011, 1, 7'b1111110, 1'b1, 1'b0, 1'b1);
        vecs[10] = mk(16'h0008, 4'b0011, 2, 7'b1111110, 1'b0, 1'b0, 1'b1);
        vecs[11] = mk(16'h0008, 4'b0011, 3, 7'b1111110, 1'b0, 1'b0, 1'b1);
        vecs[12] = mk(16'h0090, 4'b0000, 3, 7'b1111110, 1'b0, 1'b0, 1'b1);
        vecs[13] = mk(16'h0090, 4'b0000, 2, 7'b1111110, 1'b0, 1'b0, 1'b1);
        vecs[14] = mk(16'h0090, 4'b0000, 1, 7'b1111011, 1'b0, 1'b0, 1'b0);
        vecs[15] = mk(16'h0090, 4'b0000, 0, 7'b1111110, 1'b0, 1'b0, 1'b0);
        vecs[16] = mk(16'h0000, 4'b0000, 0, 7'b1111110, 1'b0, 1'b0, 1'b0);
        vecs[17] = mk(16'h0000, 4'b0000, 1, 7'b1111110, 1'b0, 1'b0, 1'b1);
        vecs[18] = mk(16'h0000, 4'b0000, 2, 7'b1111110, 1'b0, 1'b0, 1'b1);
        vecs[19] = mk(16'h0000, 4'b0000, 3, 7'b1111110, 1'b0, 1'b0, 1'b1);
        vecs[20] = mk(16'h9876, 4'b1010, 0, 7'b1011111, 1'b0, 1'b0, 1'b0);
        vecs[21] = mk(16'h9876, 4'b1010, 1, 7'b1110000, 1'b1, 1'b0, 1'b0);
        vecs[22] = mk(16'h9876, 4'b1010, 2, 7'b1111111, 1'b0, 1'b0, 1'b0);
        vecs[23] = mk(16'h9876, 4'b1010, 3, 7'b1111011, 1'b1, 1'b0, 1'b0);
        vecs[24] = mk(16'hF0C0, 4'b0000, 0, 7'b1111110, 1'b0, 1'b0, 1'b0);
        vecs[25] = mk(16'hF0C0, 4'b0000, 1, 7'b0000000, 1'b0, 1'b1, 1'b0);
        vecs[26] = mk(16'hF0C0, 4'b0000, 2, 7'b1111110, 1'b0, 1'b0, 1'b0);
        vecs[27] = mk(16'hF0C0, 4'b0000, 3, 7'b0000000, 1'b0, 1'b1, 1'b0);

        // Initial reset, checked before any clock edge
        #1 reset = 1'b1;
        #1;
        chk("rst_an_hi",  32'(an0),  32'h0);
        chk("rst_seg_hi", 32'(seg0), 32'h0);
        chk("rst_dp_hi",  32'(dp0),  32'h0);
        chk("rst_bad_hi", 32'(bad0), 32'h0);
        chk("rst_an_lo",  32'(an1),  32'hF);
        chk("rst_seg_lo", 32'(seg1), 32'h7F);
        chk("rst_dp_lo",  32'(dp1),  32'h1);
        chk("rst_bad_lo", 32'(bad1), 32'h0);
        #1 reset = 1'b0;
        edges = 0;

        // Table: load a word, then wait for the addressed digit to be on the outputs
        for (int n = 0; n < 28; n++) begin
            v     = vecs[n];
            bcd   = v.bcd;
            dp_in = v.dpi;
            load  = 1'b1;
            tick();
            load  = 1'b0;
            l     = edges;
            found = 1'b0;
            for (int t = 0; t < 24; t++) begin
                tick();
                if (edges >= l + 1 && shown(edges) == v.digit) begin
                    found = 1'b1;
                    break;
                end
            end
            chk($sformatf("v%0d_reach", n), 32'(found), 32'h1);
            e_an  = oh(v.digit);
            e_seg = exp_seg(v);
            chk($sformatf("v%0d_an_hi", n),  32'(an0),  32'(e_an));
            chk($sformatf("v%0d_seg_hi", n), 32'(seg0), 32'(e_seg));
            chk($sformatf("v%0d_dp_hi", n),  32'(dp0),  32'(v.dp));
            chk($sformatf("v%0d_bad_hi", n), 32'(bad0), 32'(v.bad));
            e_an  = ~e_an;
            e_seg = ~e_seg;
            e_dp  = ~v.dp;
            chk($sformatf("v%0d_an_lo", n),  32'(an1),  32'(e_an));
            chk($sformatf("v%0d_seg_lo", n), 32'(seg1), 32'(e_seg));
            chk($sformatf("v%0d_dp_lo", n),  32'(dp1),  32'(e_dp));
            chk($sformatf("v%0d_bad_lo", n), 32'(bad1), 32'(v.bad));
        end

        // Mid-cycle asynchronous reset with the display active
        bcd = 16'h1234; dp_in = 4'b0100; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_an_hi",  32'(an0),  32'h0);
        chk("arst_seg_hi", 32'(seg0), 32'h0);
        chk("arst_dp_hi",  32'(dp0),  32'h0);
        chk("arst_bad_hi", 32'(bad0), 32'h0);
        chk("arst_an_lo",  32'(an1),  32'hF);
        chk("arst_seg_lo", 32'(seg1), 32'h7F);
        #2 reset = 1'b0;
        edges = 0;

        // Scan restarts at digit 0 with cleared data; check a whole frame of digit enables
        for (int k = 1; k <= 16; k++) begin
            tick();
            e_an = oh(shown(edges));
            chk($sformatf("frame%0d_an_hi", k), 32'(an0), 32'(e_an));
            e_an = ~e_an;
            chk($sformatf("frame%0d_an_lo", k), 32'(an1), 32'(e_an));
            if (k == 1) begin
                chk("frame1_seg_hi", 32'(seg0), 32'h7E);
                chk("frame1_dp_hi",  32'(dp0),  32'h0);
                chk("frame1_bad_hi", 32'(bad0), 32'h0);
            end
        end

        // Blank for 10 cycles mid-frame; bad keeps following digit 1 (code A)
        bcd = 16'h00A5; dp_in = 4'b1111; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        blank = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("blank%0d_an_hi", k),  32'(an0),  32'h0);
            chk($sformatf("blank%0d_seg_hi", k), 32'(seg0), 32'h0);
            chk($sformatf("blank%0d_dp_hi", k),  32'(dp0),  32'h0);
            chk($sformatf("blank%0d_bad_hi", k), 32'(bad0), 32'(shown(edges) == 1));
            chk($sformatf("blank%0d_an_lo", k),  32'(an1),  32'hF);
            chk($sformatf("blank%0d_seg_lo", k), 32'(seg1), 32'h7F);
        end
        blank = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            e_an = oh(shown(edges));
            chk($sformatf("unblank%0d_an_hi", k), 32'(an0), 32'(e_an));
            chk($sformatf("unblank%0d_dp_hi", k), 32'(dp0), 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
